// File: rtl/axi_sram_slave.sv
// AXI3 slave endpoint over an internal word-addressed memory; write and read FSMs run independently.
// Define AXI_SLV_ERR_CHECK_EN to flag bad size/burst/out-of-range requests with SLVERR.
module axi_sram_slave #(
  parameter int IDS_W  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int DEPTH  = 1024
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [IDS_W-1:0]    AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [LEN_W-1:0]    AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [IDS_W-1:0]    BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [IDS_W-1:0]    ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [LEN_W-1:0]    ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [IDS_W-1:0]    RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int MEM_AW = $clog2(DEPTH);
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [MEM_AW-1:0] IDX_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              aw_err_s;
  logic              ar_err_s;
  logic              unused_ok_s;
  logic [MEM_AW-1:0] aw_idx_s;
  logic [MEM_AW-1:0] ar_idx_s;

  assign aw_idx_s = AWADDR[MEM_AW+1:2];
  assign ar_idx_s = ARADDR[MEM_AW+1:2];

`ifdef AXI_SLV_ERR_CHECK_EN
  function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] hi;
    hi = addr >> (MEM_AW + 2);
    return (size != 3'b010) || (burst == 2'b10) || (burst == 2'b11) || (hi != {ADDR_W{1'b0}});
  endfunction

  assign aw_err_s    = req_err(AWSIZE, AWBURST, AWADDR);
  assign ar_err_s    = req_err(ARSIZE, ARBURST, ARADDR);
  assign unused_ok_s = ^{AWADDR[1:0], ARADDR[1:0]};
`else
  // Unchecked build: upper address bits wrap away and size is ignored.
  assign aw_err_s    = 1'b0;
  assign ar_err_s    = 1'b0;
  assign unused_ok_s = ^{AWSIZE, ARSIZE, AWADDR[ADDR_W-1:MEM_AW+2], ARADDR[ADDR_W-1:MEM_AW+2],
                         AWADDR[1:0], ARADDR[1:0]};
`endif

  // ---------------- write path ----------------
  logic [1:0]        w_state_r;
  logic [IDS_W-1:0]  w_id_r;
  logic [MEM_AW-1:0] w_idx_r;
  logic [LEN_W-1:0]  w_len_r;
  logic [LEN_W-1:0]  w_cnt_r;
  logic              w_fixed_r;
  logic              w_err_r;
  logic              w_mis_r;
  logic              awready_r;
  logic              wready_r;
  logic              bvalid_r;
  logic [IDS_W-1:0]  bid_r;
  logic [1:0]        bresp_r;
  logic              w_fire_s;
  logic              w_bad_s;
  logic              mem_we_s;

  assign w_fire_s = (w_state_r == W_DATA) && WVALID && wready_r;
  // w_mis_r catches a burst that ran past LEN before WLAST finally arrived
  assign w_bad_s  = w_err_r || w_mis_r || (w_cnt_r != w_len_r);
  assign mem_we_s = w_fire_s && !w_err_r && !ARESET;

  // Write address, data and response sequencing
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_r <= W_IDLE;
      w_id_r    <= {IDS_W{1'b0}};
      w_idx_r   <= {MEM_AW{1'b0}};
      w_len_r   <= {LEN_W{1'b0}};
      w_cnt_r   <= {LEN_W{1'b0}};
      w_fixed_r <= 1'b0;
      w_err_r   <= 1'b0;
      w_mis_r   <= 1'b0;
      awready_r <= 1'b1;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= {IDS_W{1'b0}};
      bresp_r   <= RESP_OKAY;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (AWVALID) begin
            w_id_r    <= AWID;
            w_idx_r   <= aw_idx_s;
            w_len_r   <= AWLEN;
            w_cnt_r   <= {LEN_W{1'b0}};
            w_fixed_r <= (AWBURST == BURST_FIXED);
            w_err_r   <= aw_err_s;
            w_mis_r   <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b1;
            w_state_r <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire_s) begin
            w_cnt_r <= w_cnt_r + CNT_ONE;
            if (!w_fixed_r) w_idx_r <= w_idx_r + IDX_ONE;
            if (WLAST) begin
              wready_r  <= 1'b0;
              bvalid_r  <= 1'b1;
              bid_r     <= w_id_r;
              bresp_r   <= w_bad_s ? RESP_SLVERR : RESP_OKAY;
              w_state_r <= W_RESP;
            end else if (w_cnt_r == w_len_r) begin
              w_mis_r <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            bvalid_r  <= 1'b0;
            awready_r <= 1'b1;
            w_state_r <= W_IDLE;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          awready_r <= 1'b1;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane memory write; contents survive reset
  always_ff @(posedge ACLK) begin
    if (mem_we_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem_r[w_idx_r][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  logic [0:0]        r_state_r;
  logic [MEM_AW-1:0] r_idx_r;
  logic [LEN_W-1:0]  r_len_r;
  logic [LEN_W-1:0]  r_cnt_r;
  logic [LEN_W-1:0]  r_cnt_nxt_s;
  logic              r_fixed_r;
  logic              r_err_r;
  logic              arready_r;
  logic              rvalid_r;
  logic              rlast_r;
  logic [IDS_W-1:0]  rid_r;
  logic [DATA_W-1:0] rdata_r;
  logic [1:0]        rresp_r;

  assign r_cnt_nxt_s = r_cnt_r + CNT_ONE;

  // Read burst sequencing; r_idx_r always points at the next beat to load
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_r <= R_IDLE;
      r_idx_r   <= {MEM_AW{1'b0}};
      r_len_r   <= {LEN_W{1'b0}};
      r_cnt_r   <= {LEN_W{1'b0}};
      r_fixed_r <= 1'b0;
      r_err_r   <= 1'b0;
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rid_r     <= {IDS_W{1'b0}};
      rdata_r   <= {DATA_W{1'b0}};
      rresp_r   <= RESP_OKAY;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (ARVALID) begin
            r_len_r   <= ARLEN;
            r_cnt_r   <= {LEN_W{1'b0}};
            r_fixed_r <= (ARBURST == BURST_FIXED);
            r_err_r   <= ar_err_s;
            r_idx_r   <= (ARBURST == BURST_FIXED) ? ar_idx_s : ar_idx_s + IDX_ONE;
            rid_r     <= ARID;
            rdata_r   <= ar_err_s ? {DATA_W{1'b0}} : mem_r[ar_idx_s];
            rresp_r   <= ar_err_s ? RESP_SLVERR : RESP_OKAY;
            rlast_r   <= (ARLEN == {LEN_W{1'b0}});
            rvalid_r  <= 1'b1;
            arready_r <= 1'b0;
            r_state_r <= R_DATA;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            if (rlast_r) begin
              rvalid_r  <= 1'b0;
              rlast_r   <= 1'b0;
              arready_r <= 1'b1;
              r_state_r <= R_IDLE;
            end else begin
              r_cnt_r <= r_cnt_nxt_s;
              rlast_r <= (r_cnt_nxt_s == r_len_r);
              rdata_r <= r_err_r ? {DATA_W{1'b0}} : mem_r[r_idx_r];
              if (!r_fixed_r) r_idx_r <= r_idx_r + IDX_ONE;
            end
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          arready_r <= 1'b1;
          rvalid_r  <= 1'b0;
          rlast_r   <= 1'b0;
        end
      endcase
    end
  end

  assign AWREADY = awready_r;
  assign WREADY  = wready_r;
  assign BVALID  = bvalid_r;
  assign BID     = bid_r;
  assign BRESP   = bresp_r;
  assign ARREADY = arready_r;
  assign RVALID  = rvalid_r;
  assign RLAST   = rlast_r;
  assign RID     = rid_r;
  assign RDATA   = rdata_r;
  assign RRESP   = rresp_r;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave: bursts, strobes, stalls, FIXED,
// WLAST mismatch, concurrency, same-word collision and reset mid-burst.
module tb_axi_sram_slave;

  logic        ACLK;
  logic        ARESET;
  logic [7:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [7:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  axi_sram_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_assert = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int hs_before;
  logic [31:0] wbuf [16];
  logic [31:0] rexp [16];

  // R handshakes, observed mid-cycle
  always @(negedge ACLK) if (RVALID && RREADY) hs_cnt++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wr_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [3:0] strb, input int last_beat,
                          input logic [1:0] resp);
    AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
    check_eq("wr_awready", AWREADY, 1);
    step();
    AWVALID = 1'b0;
    for (int i = 0; i <= last_beat; i++) begin
      WVALID = 1'b1; WDATA = wbuf[i]; WSTRB = strb; WLAST = (i == last_beat);
      check_eq("wr_wready", WREADY, 1);
      step();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    check_eq("wr_bvalid", BVALID, 1);
    check_eq("wr_bid", BID, id);
    check_eq("wr_bresp", BRESP, resp);
    check_eq("wr_wready_drop", WREADY, 0);
    step();
    check_eq("wr_bvalid_hold", BVALID, 1);
    check_eq("wr_bresp_hold", BRESP, resp);
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    check_eq("wr_bvalid_done", BVALID, 0);
    check_eq("wr_awready_back", AWREADY, 1);
  endtask

  task automatic rd_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [1:0] resp,
                          input int stall_beat, input int stall_n);
    ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
    check_eq("rd_arready", ARREADY, 1);
    step();
    ARVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) begin
        RREADY = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          step();
          check_eq("stall_rdata", RDATA, rexp[i]);
          check_eq("stall_rlast", RLAST, (i == int'(len)));
        end
      end
      RREADY = 1'b1;
      check_eq("rd_rvalid", RVALID, 1);
      check_eq("rd_rdata", RDATA, rexp[i]);
      check_eq("rd_rid", RID, id);
      check_eq("rd_rlast", RLAST, (i == int'(len)));
      check_eq("rd_rresp", RRESP, resp);
      step();
    end
    RREADY = 1'b0;
    check_eq("rd_rvalid_done", RVALID, 0);
    check_eq("rd_arready_back", ARREADY, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ARESET = 1'b1;
    AWID = 8'h00; AWADDR = 32'h0; AWLEN = 4'h0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = 32'h0; WSTRB = 4'h0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = 8'h00; ARADDR = 32'h0; ARLEN = 4'h0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b0;
    RREADY = 1'b0;
    step(); step();
    ARESET = 1'b0;

    check_eq("rst_awready", AWREADY, 1);
    check_eq("rst_arready", ARREADY, 1);
    check_eq("rst_wready", WREADY, 0);
    check_eq("rst_bvalid", BVALID, 0);
    check_eq("rst_rvalid", RVALID, 0);
    check_eq("rst_rlast", RLAST, 0);
    check_eq("rst_bid", BID, 0);
    check_eq("rst_rid", RID, 0);
    check_eq("rst_rdata", RDATA, 0);
    check_eq("rst_bresp", BRESP, 0);
    check_eq("rst_rresp", RRESP, 0);

    // INCR burst write then read back
    wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; wbuf[2] = 32'hA2; wbuf[3] = 32'hA3;
    wr_burst(8'h12, 32'h10, 4'd3, 2'b01, 4'hF, 3, 2'b00);
    rexp[0] = 32'hA0; rexp[1] = 32'hA1; rexp[2] = 32'hA2; rexp[3] = 32'hA3;
    rd_burst(8'h34, 32'h10, 4'd3, 2'b01, 2'b00, 99, 0);

    // Byte strobes
    wbuf[0] = 32'hFFFF_FFFF;
    wr_burst(8'h01, 32'h40, 4'd0, 2'b01, 4'hF, 0, 2'b00);
    wbuf[0] = 32'h1122_3344;
    wr_burst(8'h02, 32'h40, 4'd0, 2'b01, 4'b0101, 0, 2'b00);
    rexp[0] = 32'hFF22_FF44;
    rd_burst(8'h03, 32'h40, 4'd0, 2'b01, 2'b00, 99, 0);

    // Stalled read, 3 handshakes
    hs_before = hs_cnt;
    rexp[0] = 32'hA0; rexp[1] = 32'hA1; rexp[2] = 32'hA2;
    rd_burst(8'h44, 32'h10, 4'd2, 2'b01, 2'b00, 1, 3);
    check_eq("stall_hs_count", hs_cnt - hs_before, 3);

    // FIXED burst lands on one word
    wbuf[0] = 32'h55;
    wr_burst(8'h05, 32'h24, 4'd0, 2'b01, 4'hF, 0, 2'b00);
    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3;
    wr_burst(8'h06, 32'h20, 4'd2, 2'b00, 4'hF, 2, 2'b00);
    rexp[0] = 32'd3;
    rd_burst(8'h07, 32'h20, 4'd0, 2'b01, 2'b00, 99, 0);
    rexp[0] = 32'h55;
    rd_burst(8'h08, 32'h24, 4'd0, 2'b01, 2'b00, 99, 0);

    // WLAST early and late
    wbuf[0] = 32'hC0; wbuf[1] = 32'hC1;
    wr_burst(8'h09, 32'h80, 4'd3, 2'b01, 4'hF, 1, 2'b10);
    wr_burst(8'h0A, 32'h90, 4'd0, 2'b01, 4'hF, 1, 2'b10);

    // Minimum AW-to-BVALID latency with WVALID already high
    AWID = 8'h5A; AWADDR = 32'h300; AWLEN = 4'd0; AWBURST = 2'b01; AWVALID = 1'b1;
    WVALID = 1'b1; WDATA = 32'h1234_5678; WSTRB = 4'hF; WLAST = 1'b1;
    step();
    AWVALID = 1'b0;
    check_eq("lat_bvalid_c1", BVALID, 0);
    check_eq("lat_wready_c1", WREADY, 1);
    step();
    WVALID = 1'b0; WLAST = 1'b0;
    check_eq("lat_bvalid_c2", BVALID, 1);
    check_eq("lat_bid", BID, 8'h5A);
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    check_eq("lat_awready", AWREADY, 1);

    // AW and AR accepted together
    wbuf[0] = 32'h0BAD_0BAD;
    wr_burst(8'h0B, 32'h200, 4'd0, 2'b01, 4'hF, 0, 2'b00);
    AWID = 8'h0C; AWADDR = 32'h200; AWLEN = 4'd0; AWBURST = 2'b01; AWVALID = 1'b1;
    ARID = 8'h0D; ARADDR = 32'h10; ARLEN = 4'd0; ARBURST = 2'b01; ARVALID = 1'b1;
    step();
    AWVALID = 1'b0; ARVALID = 1'b0;
    check_eq("conc_wready", WREADY, 1);
    check_eq("conc_rvalid", RVALID, 1);
    check_eq("conc_rdata", RDATA, 32'hA0);
    check_eq("conc_awready", AWREADY, 0);
    check_eq("conc_arready", ARREADY, 0);
    RREADY = 1'b1;
    step();
    RREADY = 1'b0;
    check_eq("conc_rvalid_done", RVALID, 0);

    // Write and read-load of the same word at one edge: old data returned
    WVALID = 1'b1; WDATA = 32'h600D_F00D; WSTRB = 4'hF; WLAST = 1'b1;
    ARID = 8'h0E; ARADDR = 32'h200; ARLEN = 4'd0; ARVALID = 1'b1;
    step();
    WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0;
    check_eq("coll_rdata_old", RDATA, 32'h0BAD_0BAD);
    check_eq("coll_bvalid", BVALID, 1);
    BREADY = 1'b1; RREADY = 1'b1;
    step();
    BREADY = 1'b0; RREADY = 1'b0;
    check_eq("coll_bvalid_done", BVALID, 0);
    check_eq("coll_rvalid_done", RVALID, 0);
    rexp[0] = 32'h600D_F00D;
    rd_burst(8'h0F, 32'h200, 4'd0, 2'b01, 2'b00, 99, 0);

`ifdef AXI_SLV_ERR_CHECK_EN
    rexp[0] = 32'h0;
    rd_burst(8'h10, 32'h1000, 4'd0, 2'b01, 2'b10, 99, 0);
`endif

    // Reset during beat 2 of a LEN=7 read
    ARID = 8'h77; ARADDR = 32'h10; ARLEN = 4'd7; ARBURST = 2'b01; ARVALID = 1'b1;
    step();
    ARVALID = 1'b0;
    RREADY = 1'b1;
    step(); step();
    RREADY = 1'b0;
    check_eq("midrst_beat2", RDATA, 32'hA2);
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    check_eq("midrst_rvalid", RVALID, 0);
    check_eq("midrst_arready", ARREADY, 1);
    check_eq("midrst_rlast", RLAST, 0);
    check_eq("midrst_rdata", RDATA, 0);
    rexp[0] = 32'hFF22_FF44;
    rd_burst(8'h78, 32'h40, 4'd0, 2'b01, 2'b00, 99, 0);
    rexp[0] = 32'hA0; rexp[1] = 32'hA1; rexp[2] = 32'hA2; rexp[3] = 32'hA3;
    rd_burst(8'h79, 32'h10, 4'd3, 2'b01, 2'b00, 99, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
